// File: rtl/full_adder_32_reg_pkg.sv
// Shared types and constants for the registered 32-bit ripple-carry adder.
// Defines the datapath width and the operand word type.
package full_adder_pkg;

  localparam int FA_WIDTH = 32;

  typedef logic [FA_WIDTH-1:0] word_t;

endpackage : full_adder_pkg

// File: rtl/full_adder_32_reg_if.sv
// Operand/result bundle for full_adder_32_reg; the overflow signal exists
// only when FA32_OVERFLOW_EN is defined.
interface full_adder_32_reg_if
  import full_adder_pkg::*;
#(
  parameter int WIDTH = FA_WIDTH
);

  logic [WIDTH-1:0] input1;
  logic [WIDTH-1:0] input2;
  logic             carry_in;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
`ifdef FA32_OVERFLOW_EN
  logic             overflow;
`endif

  // The adder itself is the slave: it consumes operands and returns results.
  modport slave (
    input  input1,
    input  input2,
    input  carry_in,
    output sum,
`ifdef FA32_OVERFLOW_EN
    output overflow,
`endif
    output carry_out
  );

  modport master (
    output input1,
    output input2,
    output carry_in,
    input  sum,
`ifdef FA32_OVERFLOW_EN
    input  overflow,
`endif
    input  carry_out
  );

endinterface : full_adder_32_reg_if

// File: rtl/full_adder_32_reg_1bit.sv
// One-bit full adder cell used to build the explicit ripple carry chain.
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder_1bit

// File: rtl/full_adder_32_reg.sv
// Registered ripple-carry adder: {carry_out,sum} = input1 + input2 + carry_in, 1-cycle latency.
// Optional registered signed overflow output enabled by defining FA32_OVERFLOW_EN.
module full_adder_32_reg
  import full_adder_pkg::*;
#(
  parameter int WIDTH = FA_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  full_adder_32_reg_if.slave  bus
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_comb;

  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_q;
  logic             carry_out_d;
  logic             carry_out_q;

  assign carry[0] = bus.carry_in;

  // Explicit carry chain: bit gi consumes carry[gi] and produces carry[gi+1].
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      full_adder_1bit u_bit (
        .a    (bus.input1[gi]),
        .b    (bus.input2[gi]),
        .cin  (carry[gi]),
        .s    (sum_comb[gi]),
        .cout (carry[gi+1])
      );
    end
  endgenerate

  always_comb begin
    sum_d       = sum_comb;
    carry_out_d = carry[WIDTH];
  end

`ifdef FA32_OVERFLOW_EN
  logic overflow_d;
  logic overflow_q;

  // Signed overflow: carry into the sign bit disagrees with carry out of it.
  always_comb begin
    overflow_d = carry[WIDTH-1] ^ carry[WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.overflow = overflow_q;
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q       <= '0;
      carry_out_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
    end
  end
`endif

  assign bus.sum       = sum_q;
  assign bus.carry_out = carry_out_q;

endmodule : full_adder_32_reg

// File: tb/tb_full_adder_32_reg.sv
// Self-checking bench for full_adder_32_reg: scoreboard of expected results,
// directed corner vectors, back-to-back vectors and a random sweep with mid-stream reset.
module tb_full_adder_32_reg;
  import full_adder_pkg::*;

  typedef struct packed {
    word_t sum;
    logic  cout;
    logic  ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  exp_t sb_q[$];

  full_adder_32_reg_if bus ();

  full_adder_32_reg dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference: 33-bit behavioural add plus sign-rule overflow.
  function automatic exp_t model(input word_t a, input word_t b, input logic cin, input logic rst);
    logic [FA_WIDTH:0] full;
    exp_t e;
    full   = {1'b0, a} + {1'b0, b} + {{FA_WIDTH{1'b0}}, cin};
    e.sum  = full[FA_WIDTH-1:0];
    e.cout = full[FA_WIDTH];
    e.ovf  = (a[FA_WIDTH-1] == b[FA_WIDTH-1]) && (full[FA_WIDTH-1] != a[FA_WIDTH-1]);
    if (!rst) e = '0;
    return e;
  endfunction

  // Drive one cycle of stimulus, push its expectation, and wait past the capturing edge.
  task automatic step(input word_t a, input word_t b, input logic cin, input logic rst, input exp_t e);
    bus.input1   = a;
    bus.input2   = b;
    bus.carry_in = cin;
    rst_n        = rst;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    exp_t got;
    for (int i = 0; i < 3; i++) begin
      logic  r;
      word_t a;
      word_t b;
      r = (i == 2);
      a = (i == 2) ? 32'h0000_1234 : $urandom;
      b = (i == 2) ? 32'h0000_4321 : $urandom;
      step(a, b, 1'b1, r, model(a, b, 1'b1, r));
      e   = (sb_q.size() != 0) ? sb_q.pop_front() : '1;
      got = '0;
      got.sum  = bus.sum;
      got.cout = bus.carry_out;
`ifdef FA32_OVERFLOW_EN
      got.ovf  = bus.overflow;
`else
      e.ovf    = 1'b0;
`endif
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL reset[%0d]: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                 i, got.sum, got.cout, got.ovf, e.sum, e.cout, e.ovf);
      end else begin
        $display("reset[%0d] rst_n=%b a=%h b=%h -> sum=%h cout=%b", i, r, a, b, got.sum, got.cout);
      end
    end
  endtask

  task automatic test_directed();
    word_t ta [5] = '{32'h5AD7_6D6B, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000};
    word_t tb_[5] = '{32'h30D6_4F61, 32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000};
    logic  tc [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_t  te [5] = '{{32'h8BAD_BCCC, 1'b0, 1'b1},
                      {32'h0000_0000, 1'b1, 1'b0},
                      {32'hFFFF_FFFE, 1'b1, 1'b0},
                      {32'h0000_0000, 1'b1, 1'b1},
                      {32'h0000_0000, 1'b0, 1'b0}};
    exp_t e;
    exp_t got;
    for (int i = 0; i < 5; i++) begin
      step(ta[i], tb_[i], tc[i], 1'b1, te[i]);
      e   = (sb_q.size() != 0) ? sb_q.pop_front() : '1;
      got = '0;
      got.sum  = bus.sum;
      got.cout = bus.carry_out;
`ifdef FA32_OVERFLOW_EN
      got.ovf  = bus.overflow;
`else
      e.ovf    = 1'b0;
`endif
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL directed[%0d]: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                 i, got.sum, got.cout, got.ovf, e.sum, e.cout, e.ovf);
      end else begin
        $display("directed[%0d] %h+%h+%b -> sum=%h cout=%b", i, ta[i], tb_[i], tc[i], got.sum, got.cout);
      end
    end
  endtask

  task automatic test_back_to_back();
    word_t ta [2] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF};
    word_t tb_[2] = '{32'hFFFF_FFFF, 32'h0000_0001};
    logic  tc [2] = '{1'b1, 1'b0};
    exp_t  te [2] = '{{32'hFFFF_FFFF, 1'b1, 1'b0},
                      {32'h8000_0000, 1'b0, 1'b1}};
    exp_t e;
    exp_t got;
    for (int i = 0; i < 2; i++) begin
      step(ta[i], tb_[i], tc[i], 1'b1, te[i]);
      e   = (sb_q.size() != 0) ? sb_q.pop_front() : '1;
      got = '0;
      got.sum  = bus.sum;
      got.cout = bus.carry_out;
`ifdef FA32_OVERFLOW_EN
      got.ovf  = bus.overflow;
`else
      e.ovf    = 1'b0;
`endif
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                 i, got.sum, got.cout, got.ovf, e.sum, e.cout, e.ovf);
      end else begin
        $display("back_to_back[%0d] %h+%h+%b -> sum=%h cout=%b", i, ta[i], tb_[i], tc[i], got.sum, got.cout);
      end
    end
  endtask

  task automatic test_random_sweep();
    exp_t  e;
    exp_t  got;
    int    sweep_fail;
    sweep_fail = 0;
    for (int i = 0; i < 10000; i++) begin
      word_t a;
      word_t b;
      logic  cin;
      logic  r;
      a   = $urandom;
      b   = $urandom;
      cin = 1'($urandom_range(0, 1));
      if (i % 4 == 0) a = {a[31], {31{a[30]}}};
      r   = !(i == 5000 || i == 5001);
      step(a, b, cin, r, model(a, b, cin, r));
      e   = (sb_q.size() != 0) ? sb_q.pop_front() : '1;
      got = '0;
      got.sum  = bus.sum;
      got.cout = bus.carry_out;
`ifdef FA32_OVERFLOW_EN
      got.ovf  = bus.overflow;
`else
      e.ovf    = 1'b0;
`endif
      n_checks++;
      if (got !== e) begin
        n_fail++;
        sweep_fail++;
        if (sweep_fail <= 10)
          $display("FAIL random[%0d]: %h+%h+%b rst_n=%b got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                   i, a, b, cin, r, got.sum, got.cout, got.ovf, e.sum, e.cout, e.ovf);
      end
      if (!r) $display("random[%0d] reset mid-sweep -> sum=%h cout=%b", i, got.sum, got.cout);
    end
    $display("random sweep: 10000 vectors, %0d discrepancies", sweep_fail);
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    bus.input1   = '0;
    bus.input2   = '0;
    bus.carry_in = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random_sweep();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_full_adder_32_reg
